// File: rtl/rv32i_forwarding_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_forwarding_scoreboard
//  Brief    : EX-stage operand bypass selection and hazard detection for
//             NUM_SRC operands across NUM_FWD_STAGES bypass stages, with a
//             per-register latency scoreboard for multi-cycle producers.
//             Optional stall-cycle statistics counter under the
//             RV32I_FWD_STATS_EN macro (adds output stall_cycles_o).
//  Revision : 1.0 - initial release
// ============================================================================
module rv32i_forwarding_scoreboard #(
    parameter  int NUM_SRC             = 2,
    parameter  int NUM_FWD_STAGES      = 2,
    parameter  int MAX_LATENCY         = 4,
    parameter  int PRIORITIZE_YOUNGEST = 1,
    localparam int SEL_W               = $clog2(NUM_FWD_STAGES + 1),
    localparam int LAT_W               = $clog2(MAX_LATENCY + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  logic [NUM_SRC*5-1:0]        ex_rs_addr_i,
    input  logic [NUM_SRC-1:0]          ex_rs_used_i,
    input  logic [NUM_FWD_STAGES*5-1:0] fwd_rd_addr_i,
    input  logic [NUM_FWD_STAGES-1:0]   fwd_regwrite_i,
    input  logic [NUM_FWD_STAGES-1:0]   fwd_data_ready_i,
    input  logic                        issue_valid_i,
    input  logic [4:0]                  issue_rd_addr_i,
    input  logic                        issue_regwrite_i,
    input  logic [LAT_W-1:0]            issue_latency_i,
    output logic [NUM_SRC*SEL_W-1:0]    forward_sel_o,
    output logic                        stall_o,
    output logic [31:0]                 sb_pending_o
`ifdef RV32I_FWD_STATS_EN
    ,
    output logic [31:0]                 stall_cycles_o
`endif
);

    localparam logic [LAT_W-1:0] c_MAX_LAT = LAT_W'(MAX_LATENCY);

    logic [NUM_SRC*NUM_FWD_STAGES-1:0] w_match;
    logic [NUM_SRC*SEL_W-1:0]          w_sel;
    logic [NUM_SRC-1:0]                w_data_haz;
    logic [NUM_SRC-1:0]                w_sb_haz;
    logic [31:0]                       w_pending;
    logic                              w_stall;
    logic                              w_issue;
    logic [LAT_W-1:0]                  w_issue_lat;

    // Per operand/stage match; an unused operand never matches, so its
    // select falls back to the register file and it raises no hazard.
    genvar k, s;
    generate
        for (k = 0; k < NUM_SRC; k++) begin : g_src
            for (s = 0; s < NUM_FWD_STAGES; s++) begin : g_stage
                assign w_match[k*NUM_FWD_STAGES+s] =
                    ex_rs_used_i[k] & fwd_regwrite_i[s] &
                    (fwd_rd_addr_i[s*5 +: 5] != 5'd0) &
                    (fwd_rd_addr_i[s*5 +: 5] == ex_rs_addr_i[k*5 +: 5]);
            end
            assign w_sb_haz[k] = ex_rs_used_i[k] & w_pending[ex_rs_addr_i[k*5 +: 5]];
        end
    endgenerate

    // Priority select: scan so the preferred stage is visited last and wins.
    always_comb begin
        w_sel      = '0;
        w_data_haz = '0;
        for (int q = 0; q < NUM_SRC; q++) begin
            for (int i = 0; i < NUM_FWD_STAGES; i++) begin
                if (PRIORITIZE_YOUNGEST != 0) begin
                    if (w_match[q*NUM_FWD_STAGES + (NUM_FWD_STAGES-1-i)]) begin
                        w_sel[q*SEL_W +: SEL_W] = SEL_W'(NUM_FWD_STAGES - i);
                        w_data_haz[q]           = ~fwd_data_ready_i[NUM_FWD_STAGES-1-i];
                    end
                end else begin
                    if (w_match[q*NUM_FWD_STAGES + i]) begin
                        w_sel[q*SEL_W +: SEL_W] = SEL_W'(i + 1);
                        w_data_haz[q]           = ~fwd_data_ready_i[i];
                    end
                end
            end
        end
    end

    assign w_stall       = (|w_data_haz) | (|w_sb_haz);
    assign forward_sel_o = w_sel;
    assign stall_o       = w_stall;

    // A stalled or flushed instruction never reaches the scoreboard.
    assign w_issue     = issue_valid_i & issue_regwrite_i & (issue_rd_addr_i != 5'd0)
                       & ~w_stall & ~flush_i;
    assign w_issue_lat = (issue_latency_i > c_MAX_LAT) ? c_MAX_LAT : issue_latency_i;

    // x0 is never written, so its counter does not exist.
    assign w_pending[0] = 1'b0;

    genvar r;
    generate
        for (r = 1; r < 32; r++) begin : g_sb
            logic [LAT_W-1:0] r_cnt;

            // Flush beats issue; a fresh issue beats the running countdown.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_cnt <= '0;
                end else if (flush_i) begin
                    r_cnt <= '0;
                end else if (w_issue && (issue_rd_addr_i == 5'(r))) begin
                    r_cnt <= w_issue_lat;
                end else if (r_cnt != '0) begin
                    r_cnt <= r_cnt - LAT_W'(1);
                end
            end

            assign w_pending[r] = (r_cnt != '0);
        end
    endgenerate

    assign sb_pending_o = w_pending;

`ifdef RV32I_FWD_STATS_EN
    logic [31:0] r_stall_cycles;

    // Saturating count of stalled cycles; only reset clears it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles_o = r_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rv32i_forwarding_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv32i_forwarding_scoreboard
//  Brief    : Directed, table-driven bench for rv32i_forwarding_scoreboard.
//             Two instances share stimulus: youngest-first and oldest-first.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_forwarding_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [9:0]  rs_addr;
    logic [1:0]  rs_used;
    logic [9:0]  fwd_rd;
    logic [1:0]  fwd_we;
    logic [1:0]  fwd_rdy;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_we;
    logic [2:0]  iss_lat;

    logic [3:0]  sel_y,   sel_o;
    logic        stall_y, stall_o;
    logic [31:0] pend_y,  pend_o;
`ifdef RV32I_FWD_STATS_EN
    logic [31:0] stats_y, stats_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rv32i_forwarding_scoreboard #(
        .NUM_SRC(2), .NUM_FWD_STAGES(2), .MAX_LATENCY(4), .PRIORITIZE_YOUNGEST(1)
    ) dut_y (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .ex_rs_addr_i(rs_addr), .ex_rs_used_i(rs_used),
        .fwd_rd_addr_i(fwd_rd), .fwd_regwrite_i(fwd_we), .fwd_data_ready_i(fwd_rdy),
        .issue_valid_i(iss_valid), .issue_rd_addr_i(iss_rd),
        .issue_regwrite_i(iss_we), .issue_latency_i(iss_lat),
        .forward_sel_o(sel_y), .stall_o(stall_y), .sb_pending_o(pend_y)
`ifdef RV32I_FWD_STATS_EN
        , .stall_cycles_o(stats_y)
`endif
    );

    rv32i_forwarding_scoreboard #(
        .NUM_SRC(2), .NUM_FWD_STAGES(2), .MAX_LATENCY(4), .PRIORITIZE_YOUNGEST(0)
    ) dut_o (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .ex_rs_addr_i(rs_addr), .ex_rs_used_i(rs_used),
        .fwd_rd_addr_i(fwd_rd), .fwd_regwrite_i(fwd_we), .fwd_data_ready_i(fwd_rdy),
        .issue_valid_i(iss_valid), .issue_rd_addr_i(iss_rd),
        .issue_regwrite_i(iss_we), .issue_latency_i(iss_lat),
        .forward_sel_o(sel_o), .stall_o(stall_o), .sb_pending_o(pend_o)
`ifdef RV32I_FWD_STATS_EN
        , .stall_cycles_o(stats_o)
`endif
    );

    typedef struct {
        logic [9:0] rs;
        logic [1:0] used;
        logic [9:0] rd;
        logic [1:0] we;
        logic [1:0] rdy;
        logic [3:0] sel_y;
        logic       stall_y;
        logic [3:0] sel_o;
        logic       stall_o;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush     = 1'b0;
        rs_addr   = '0;
        rs_used   = '0;
        fwd_rd    = '0;
        fwd_we    = '0;
        fwd_rdy   = 2'b11;
        iss_valid = 1'b0;
        iss_rd    = '0;
        iss_we    = 1'b0;
        iss_lat   = '0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [2:0] lat);
        iss_valid = 1'b1;
        iss_we    = 1'b1;
        iss_rd    = rd;
        iss_lat   = lat;
    endtask

    initial begin
        // rs = {op1, op0}; rd = {stage1, stage0}; sel = {op1[1:0], op0[1:0]}
        vecs[0] = '{{5'd0, 5'd0}, 2'b00, {5'd0, 5'd0}, 2'b00, 2'b11, 4'b0000, 1'b0, 4'b0000, 1'b0};
        vecs[1] = '{{5'd0, 5'd5}, 2'b11, {5'd5, 5'd5}, 2'b11, 2'b11, 4'b0001, 1'b0, 4'b0010, 1'b0};
        vecs[2] = '{{5'd0, 5'd0}, 2'b11, {5'd0, 5'd0}, 2'b11, 2'b11, 4'b0000, 1'b0, 4'b0000, 1'b0};
        vecs[3] = '{{5'd7, 5'd1}, 2'b11, {5'd1, 5'd7}, 2'b11, 2'b10, 4'b0110, 1'b1, 4'b0110, 1'b1};
        vecs[4] = '{{5'd7, 5'd1}, 2'b11, {5'd1, 5'd7}, 2'b11, 2'b11, 4'b0110, 1'b0, 4'b0110, 1'b0};
        vecs[5] = '{{5'd7, 5'd2}, 2'b01, {5'd0, 5'd7}, 2'b01, 2'b00, 4'b0000, 1'b0, 4'b0000, 1'b0};
        vecs[6] = '{{5'd0, 5'd7}, 2'b01, {5'd0, 5'd7}, 2'b00, 2'b11, 4'b0000, 1'b0, 4'b0000, 1'b0};
        vecs[7] = '{{5'd0, 5'd5}, 2'b01, {5'd5, 5'd5}, 2'b11, 2'b10, 4'b0001, 1'b1, 4'b0010, 1'b0};
        vecs[8] = '{{5'd3, 5'd4}, 2'b11, {5'd4, 5'd3}, 2'b11, 2'b11, 4'b0110, 1'b0, 4'b0110, 1'b0};
        vecs[9] = '{{5'd5, 5'd0}, 2'b10, {5'd5, 5'd5}, 2'b11, 2'b11, 4'b0100, 1'b0, 4'b1000, 1'b0};

        idle();
        rst_n = 1'b0;
        tick();
        #1;
        check("reset_pending", pend_y, 32'h0);
        check("reset_stall", {31'd0, stall_y}, 32'h0);
        check("reset_sel", {28'd0, sel_y}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_reset_pending", pend_o, 32'h0);

        // Combinational forwarding table
        for (int i = 0; i < 10; i++) begin
            rs_addr = vecs[i].rs;
            rs_used = vecs[i].used;
            fwd_rd  = vecs[i].rd;
            fwd_we  = vecs[i].we;
            fwd_rdy = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d_sel_young", i),   {28'd0, sel_y},   {28'd0, vecs[i].sel_y});
            check($sformatf("vec%0d_stall_young", i), {31'd0, stall_y}, {31'd0, vecs[i].stall_y});
            check($sformatf("vec%0d_sel_old", i),     {28'd0, sel_o},   {28'd0, vecs[i].sel_o});
            check($sformatf("vec%0d_stall_old", i),   {31'd0, stall_o}, {31'd0, vecs[i].stall_o});
        end

        // Latency 3 on x9: exactly three stalled cycles
        idle();
        issue(5'd9, 3'd3);
        tick();
        idle();
        rs_addr = {5'd0, 5'd9};
        rs_used = 2'b01;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("cd3_stall_c%0d", i), {31'd0, stall_y}, {31'd0, (i < 3)});
            check($sformatf("cd3_pend9_c%0d", i), {31'd0, pend_y[9]}, {31'd0, (i < 3)});
            tick();
        end

        // Latency 7 clamps to MAX_LATENCY = 4
        idle();
        issue(5'd9, 3'd7);
        tick();
        idle();
        rs_addr = {5'd0, 5'd9};
        rs_used = 2'b01;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("clamp_stall_c%0d", i), {31'd0, stall_y}, {31'd0, (i < 4)});
            tick();
        end

        // Reload of x3 while its counter is 1: load wins over decrement
        idle();
        issue(5'd3, 3'd1);
        tick();
        issue(5'd3, 3'd2);
        tick();
        idle();
        #1;
        check("reload_pend3_a", {31'd0, pend_y[3]}, 32'd1);
        tick();
        check("reload_pend3_b", {31'd0, pend_y[3]}, 32'd1);
        tick();
        check("reload_pend3_c", {31'd0, pend_y[3]}, 32'd0);

        // Issue is ignored while stalled (load-use on x7)
        idle();
        fwd_rd  = {5'd0, 5'd7};
        fwd_we  = 2'b01;
        fwd_rdy = 2'b00;
        rs_addr = {5'd0, 5'd7};
        rs_used = 2'b01;
        issue(5'd11, 3'd3);
        tick();
        idle();
        #1;
        check("stall_gates_issue", pend_y, 32'h0);

        // Flush clears counters and beats a same-cycle issue
        idle();
        issue(5'd4, 3'd3);
        tick();
        issue(5'd8, 3'd2);
        tick();
        idle();
        #1;
        check("pre_flush_pending", pend_y, 32'h0000_0110);
        flush   = 1'b1;
        issue(5'd10, 3'd3);
        fwd_rd  = {5'd0, 5'd5};
        fwd_we  = 2'b01;
        rs_addr = {5'd0, 5'd5};
        rs_used = 2'b01;
        #1;
        check("flush_keeps_fwd", {28'd0, sel_y}, 32'd1);
        tick();
        idle();
        #1;
        check("post_flush_pending", pend_y, 32'h0);

        // Asynchronous reset mid-countdown
        idle();
        issue(5'd12, 3'd4);
        tick();
        idle();
        #1;
        check("pre_reset_pending", pend_y, 32'h0000_1000);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_pending", pend_y, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

`ifdef RV32I_FWD_STATS_EN
        check("stats_reset", stats_y, 32'd0);
        idle();
        fwd_rd  = {5'd0, 5'd7};
        fwd_we  = 2'b01;
        fwd_rdy = 2'b00;
        rs_addr = {5'd0, 5'd7};
        rs_used = 2'b01;
        flush   = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        idle();
        tick();
        check("stats_five", stats_y, 32'd5);
        dut_y.r_stall_cycles = 32'hFFFF_FFFD;
        fwd_rd  = {5'd0, 5'd7};
        fwd_we  = 2'b01;
        fwd_rdy = 2'b00;
        rs_addr = {5'd0, 5'd7};
        rs_used = 2'b01;
        for (int i = 0; i < 4; i++) tick();
        check("stats_saturate", stats_y, 32'hFFFF_FFFF);
        idle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
